div_share_arbiter: RTL and testbench
====================================

// Module: div_share_arbiter
// PURPOSE
//  Shares one non-restoring divider (WIDTH-bit dividend Q, divisor M, accumulator A, start/done)
//  between NREQ requesters in the RSA decryption datapath, e.g. modular-reduction and CRT units.
//  - Round-robin grant; captures the winner's operands and sequences the divider start/done handshake.
//  - Returns quotient/remainder to the winner over a valid/ready response channel.
//  - Short-circuits divide-by-zero without using the divider.
// PARAMETERS
//  WIDTH          512   operand/result width in bits
//  NREQ           2     number of requesters (>=2)
//  IDW            1     width of rsp_id, = clog2(NREQ)
//  TIMEOUT_CYCLES 1100  watchdog limit in WAIT (used only with DIV_TIMEOUT_EN)
// PORTS
//  clk           in   1           single clock, rising edge
//  rst           in   1           synchronous reset, active-high
//  req_valid     in   NREQ        per-requester request valid
//  req_ready     out  NREQ        one-hot accept strobe
//  req_dividend  in   NREQ*WIDTH  requester i at [i*WIDTH +: WIDTH]
//  req_divisor   in   NREQ*WIDTH  same packing
//  rsp_valid     out  NREQ        one-hot response valid to the granted requester
//  rsp_ready     in   NREQ        per-requester response accept
//  rsp_id        out  IDW         index of the responding requester
//  rsp_quot      out  WIDTH       quotient
//  rsp_rem       out  WIDTH       remainder
//  rsp_err       out  1           1 = divide-by-zero or timeout
//  div_Q         out  WIDTH       divider dividend
//  div_M         out  WIDTH       divider divisor
//  div_A         out  WIDTH       divider accumulator; constant 0
//  div_start     out  1           one-cycle divider start pulse
//  div_Q_out     in   WIDTH       divider quotient
//  div_R         in   WIDTH       divider remainder
//  div_done      in   1           divider completion
// BEHAVIOUR
//  - Reset: every output is 0; state = IDLE; rr_ptr = NREQ-1, so requester 0 has first priority.
//    rst takes effect mid-operation and abandons any transaction with no response.
//  - States:
//    - IDLE: if any req_valid, grant the first set bit searching from rr_ptr+1 with wrap-around.
//      - In the same cycle, req_ready[g] = 1 combinationally; latch dividend, divisor and g; set rr_ptr <= g.
//      - If divisor == 0, go to RESP with quot = all ones, rem = dividend, err = 1.
//      - Otherwise go to START.
//    - START: div_start = 1 for exactly this cycle, then go to WAIT.
//    - WAIT: when div_done = 1, latch div_Q_out/div_R into rsp_quot/rsp_rem, set err = 0, go to RESP.
//  - div_Q/div_M hold the latched operands from START until WAIT exits; div_done is ignored outside WAIT.
//  - RESP: rsp_valid[g] = 1 with rsp_id = g. rsp_quot, rsp_rem and rsp_err stay stable until
//    rsp_ready[g] = 1, then go to IDLE. rsp_ready bits of other requesters are ignored.
//  - Only one transaction is in flight; req_ready = 0 in every non-IDLE state.
//  - Latency: accept at cycle 0, div_start at cycle 1; rsp_valid rises one cycle after div_done is sampled.
//    Divide-by-zero: rsp_valid at cycle 1.
//  - Back-to-back: IDLE may accept a new request in the cycle after the response handshake.
//  - A requester that drops req_valid before its grant is simply skipped; grant decisions use current inputs only.
// CONFIGURATION
//  - DIV_TIMEOUT_EN defined:
//    - A counter clears on entering WAIT and increments each WAIT cycle.
//    - At TIMEOUT_CYCLES without div_done, go to RESP with quot = 0, rem = 0, err = 1.
//    - Then hold div_start low for 2 extra cycles in IDLE before the next grant.
//    - div_done in the same cycle as expiry wins (normal result, err = 0).
//  - DIV_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely; rsp_err only flags divide-by-zero.
// TESTING
//  1. Reset, then req0 with 100/7 -> req_ready[0] pulse, single div_start, rsp_valid[0], quot = 14, rem = 2, err = 0.
//  2. req0 and req1 valid together, both held for 3 ops -> grants 0,1,0; each response carries the matching rsp_id.
//  3. Divisor 0, dividend 55 -> no div_start; rsp_valid at cycle 1; quot = all ones, rem = 55, err = 1.
//  4. Hold rsp_ready low 10 cycles -> rsp_valid and data stable, req_ready stays 0; release -> IDLE next cycle.
//  5. Assert rst during WAIT -> all outputs 0 next cycle; a late div_done produces no response.
//  6. DIV_TIMEOUT_EN with TIMEOUT_CYCLES = 8 and div_done held low -> response after 8 WAIT cycles, err = 1, quot = rem = 0.

Source files
------------

// File: rtl/div_share_arbiter_if.sv
// Request/response bundle between the requesters and the shared-divider arbiter.
// slave = arbiter side, master = requester side.
interface div_share_arbiter_if #(
    parameter int WIDTH = 512,
    parameter int NREQ  = 2,
    parameter int IDW   = 1
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_dividend;
    logic [NREQ*WIDTH-1:0] req_divisor;
    logic [NREQ-1:0]       rsp_valid;
    logic [NREQ-1:0]       rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_quot;
    logic [WIDTH-1:0]      rsp_rem;
    logic                  rsp_err;

    modport slave (
        input  req_valid, req_dividend, req_divisor, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err
    );

    modport master (
        output req_valid, req_dividend, req_divisor, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_quot, rsp_rem, rsp_err
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter sharing one divider among NREQ requesters; divide-by-zero answered without the divider.
// Latency: accept cycle 0, div_start cycle 1, response one cycle after div_done (cycle 1 for divide-by-zero).
// Backpressure: one transaction in flight; req_ready stays low until the response handshake. Option: DIV_TIMEOUT_EN.
module div_share_arbiter #(
    parameter int WIDTH          = 512,
    parameter int NREQ           = 2,
    parameter int IDW            = 1,
    parameter int TIMEOUT_CYCLES = 1100
) (
    input  logic               clk,
    input  logic               rst,
    div_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0]   div_Q,
    output logic [WIDTH-1:0]   div_M,
    output logic [WIDTH-1:0]   div_A,
    output logic               div_start,
    input  logic [WIDTH-1:0]   div_Q_out,
    input  logic [WIDTH-1:0]   div_R,
    input  logic               div_done
);
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_RESP} state_t;

    state_t           state, state_n;
    logic [IDW-1:0]   rr_ptr, id_q, gnt;
    logic [WIDTH-1:0] dvd_q, dvs_q, quot_q, rem_q;
    logic [WIDTH-1:0] sel_dvd, sel_dvs;
    logic             err_q, found, accept, dvs_zero;
    logic             timeout_hit, hold_ok;
    int               idx;

    // Round-robin search starting just after the last winner, wrapping around.
    always_comb begin
        found   = 1'b0;
        gnt     = '0;
        idx     = 0;
        sel_dvd = '0;
        sel_dvs = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req_valid[IDW'(idx)]) begin
                found = 1'b1;
                gnt   = IDW'(idx);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == IDW'(i)) begin
                sel_dvd = bus.req_dividend[i*WIDTH +: WIDTH];
                sel_dvs = bus.req_divisor[i*WIDTH +: WIDTH];
            end
        end
    end

    assign dvs_zero = (sel_dvs == '0);
    assign accept   = (state == ST_IDLE) && found && hold_ok && !rst;

    always_comb begin
        state_n       = state;
        bus.req_ready = '0;
        div_start     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    bus.req_ready = NREQ'(1) << gnt;
                    state_n       = dvs_zero ? ST_RESP : ST_START;
                end
            end
            ST_START: begin
                div_start = 1'b1;
                state_n   = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_done || timeout_hit) state_n = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready[id_q]) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            rr_ptr <= IDW'(NREQ - 1);
            id_q   <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            if (accept) begin
                rr_ptr <= gnt;
                id_q   <= gnt;
                dvd_q  <= sel_dvd;
                dvs_q  <= sel_dvs;
                if (dvs_zero) begin
                    quot_q <= '1;
                    rem_q  <= sel_dvd;
                    err_q  <= 1'b1;
                end
            end else if (state == ST_WAIT && div_done) begin
                quot_q <= div_Q_out;
                rem_q  <= div_R;
                err_q  <= 1'b0;
            end else if (timeout_hit) begin
                quot_q <= '0;
                rem_q  <= '0;
                err_q  <= 1'b1;
            end
        end
    end

`ifdef DIV_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;
    logic [1:0]     hold_cnt;
    logic           to_flag;

    // div_done arriving on the expiry cycle takes priority over the watchdog.
    assign timeout_hit = (state == ST_WAIT) && !div_done && (wd_cnt == WDW'(TIMEOUT_CYCLES - 1));
    assign hold_ok     = (hold_cnt == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt   <= '0;
            hold_cnt <= 2'd0;
            to_flag  <= 1'b0;
        end else begin
            if (state == ST_START)     wd_cnt <= '0;
            else if (state == ST_WAIT) wd_cnt <= wd_cnt + 1'b1;
            if (timeout_hit) to_flag <= 1'b1;
            if (state == ST_RESP && bus.rsp_ready[id_q]) begin
                to_flag  <= 1'b0;
                hold_cnt <= to_flag ? 2'd2 : 2'd0;
            end else if (state == ST_IDLE && hold_cnt != 2'd0) begin
                hold_cnt <= hold_cnt - 2'd1;
            end
        end
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
    assign hold_ok        = 1'b1;
`endif

    assign div_Q = (state == ST_START || state == ST_WAIT) ? dvd_q : '0;
    assign div_M = (state == ST_START || state == ST_WAIT) ? dvs_q : '0;
    assign div_A = '0;

    assign bus.rsp_valid = (state == ST_RESP) ? (NREQ'(1) << id_q) : '0;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_quot  = quot_q;
    assign bus.rsp_rem   = rem_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_div_share_arbiter.sv
// Bench for div_share_arbiter: vector table with a response scoreboard plus multi-cycle corner sequences.
module tb_div_share_arbiter;
    localparam int W    = 32;
    localparam int NREQ = 2;
    localparam int IDW  = 1;
    localparam int TO   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_share_arbiter_if #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW)) bus();

    logic [W-1:0] div_Q, div_M, div_A;
    logic [W-1:0] div_Q_out = '0;
    logic [W-1:0] div_R     = '0;
    logic         div_start;
    logic         div_done  = 1'b0;

    div_share_arbiter #(.WIDTH(W), .NREQ(NREQ), .IDW(IDW), .TIMEOUT_CYCLES(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .div_Q     (div_Q),
        .div_M     (div_M),
        .div_A     (div_A),
        .div_start (div_start),
        .div_Q_out (div_Q_out),
        .div_R     (div_R),
        .div_done  (div_done)
    );

    typedef struct {
        int           id;
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic [W-1:0] quot;
        logic [W-1:0] rem;
        logic         err;
    } vec_t;

    typedef struct {
        int           id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   start_cnt = 0;
    bit   model_en = 1'b1;
    bit   manual_done = 1'b0;

    // Divider model: result appears three falling edges after the start pulse.
    logic [W-1:0] oq, om;
    int           lat_cnt = 0;
    bit           pend = 1'b0;
    always @(negedge clk) begin
        div_done = manual_done;
        if (rst) begin
            pend = 1'b0;
        end else if (div_start) begin
            start_cnt++;
            if (model_en) begin
                pend    = 1'b1;
                lat_cnt = 2;
                oq      = div_Q;
                om      = div_M;
            end
        end else if (pend) begin
            if (lat_cnt == 0) begin
                div_done  = 1'b1;
                div_Q_out = (om == '0) ? '1 : oq / om;
                div_R     = (om == '0) ? '1 : oq % om;
                pend      = 1'b0;
            end else begin
                lat_cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [W-1:0] q, input logic [W-1:0] r, input logic e);
        exp_t x;
        x.id = id; x.q = q; x.r = r; x.e = e;
        exp_q.push_back(x);
    endtask

    task automatic set_ops(input int id, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        if (id == 0) begin
            bus.req_dividend[W-1:0] = dvd;
            bus.req_divisor[W-1:0]  = dvs;
        end else begin
            bus.req_dividend[2*W-1:W] = dvd;
            bus.req_divisor[2*W-1:W]  = dvs;
        end
    endtask

    // Present one request from an otherwise idle requester set and take it through acceptance.
    task automatic issue(input int id, input logic [W-1:0] dvd, input logic [W-1:0] dvs);
        logic [NREQ-1:0] oh;
        oh = NREQ'(1) << id;
        set_ops(id, dvd, dvs);
        bus.req_valid = bus.req_valid | oh;
        #1;
        chk("req_ready_accept", W'(bus.req_ready), W'(oh));
        tick();
        bus.req_valid = bus.req_valid & ~oh;
    endtask

    task automatic collect(output int lat, input int hold);
        int              n;
        exp_t            e;
        logic [NREQ-1:0] oh;
        logic            stable;
        n = 0;
        while (bus.rsp_valid == '0 && n < 60) begin
            tick();
            n++;
        end
        lat = n;
        if (bus.rsp_valid == '0) begin
            n_vec++; n_bad++;
            $display("FAIL rsp_timeout: no rsp_valid after %0d cycles", n);
            return;
        end
        if (exp_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL unexpected_rsp: rsp_id %0d, nothing expected", bus.rsp_id);
            return;
        end
        e  = exp_q.pop_front();
        oh = NREQ'(1) << e.id;
        chk("rsp_valid", W'(bus.rsp_valid), W'(oh));
        chk("rsp_id",    W'(bus.rsp_id),    W'(e.id));
        chk("rsp_quot",  bus.rsp_quot,      e.q);
        chk("rsp_rem",   bus.rsp_rem,       e.r);
        chk("rsp_err",   W'(bus.rsp_err),   W'(e.e));
        if (hold > 0) begin
            stable = 1'b1;
            bus.rsp_ready = ~oh;
            for (int k = 0; k < hold; k++) begin
                tick();
                if (bus.rsp_valid !== oh || bus.rsp_quot !== e.q || bus.rsp_rem !== e.r ||
                    bus.rsp_err !== e.e || bus.req_ready !== '0)
                    stable = 1'b0;
            end
            chk("rsp_hold_stable", W'(stable), W'(1));
        end
        bus.rsp_ready = oh;
        tick();
        bus.rsp_ready = '0;
        chk("rsp_release", W'(bus.rsp_valid), '0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    vec_t tbl[8];
    int   lat, sc;
    int   exp_g[3];
    bit   seen;

    initial begin
        tbl[0] = '{0, 32'd100,        32'd7,      32'd14,         32'd2,     1'b0};
        tbl[1] = '{1, 32'd1000,       32'd10,     32'd100,        32'd0,     1'b0};
        tbl[2] = '{0, 32'd55,         32'd0,      32'hFFFF_FFFF,  32'd55,    1'b1};
        tbl[3] = '{1, 32'hFFFF_FFFF,  32'd1,      32'hFFFF_FFFF,  32'd0,     1'b0};
        tbl[4] = '{0, 32'd3,          32'd9,      32'd0,          32'd3,     1'b0};
        tbl[5] = '{1, 32'd0,          32'd0,      32'hFFFF_FFFF,  32'd0,     1'b1};
        tbl[6] = '{0, 32'hDEAD_BEEF,  32'h1234,   32'h000C_3BA5,  32'h76B,   1'b0};
        tbl[7] = '{1, 32'd0,          32'd5,      32'd0,          32'd0,     1'b0};
        exp_g  = '{0, 1, 0};

        bus.req_valid    = 2'b11;
        bus.req_dividend = '0;
        bus.req_divisor  = '0;
        bus.rsp_ready    = '0;
        tick();
        tick();
        chk("rst_req_ready", W'(bus.req_ready), '0);
        chk("rst_rsp_valid", W'(bus.rsp_valid), '0);
        chk("rst_rsp_id",    W'(bus.rsp_id),    '0);
        chk("rst_rsp_quot",  bus.rsp_quot,      '0);
        chk("rst_rsp_rem",   bus.rsp_rem,       '0);
        chk("rst_rsp_err",   W'(bus.rsp_err),   '0);
        chk("rst_div_start", W'(div_start),     '0);
        chk("rst_div_Q",     div_Q,             '0);
        chk("rst_div_M",     div_M,             '0);
        chk("rst_div_A",     div_A,             '0);
        bus.req_valid = '0;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            sc = start_cnt;
            issue(tbl[i].id, tbl[i].dvd, tbl[i].dvs);
            push_exp(tbl[i].id, tbl[i].quot, tbl[i].rem, tbl[i].err);
            if (tbl[i].dvs != '0) begin
                chk("div_start_c1", W'(div_start), W'(1));
                chk("div_Q_c1",     div_Q,         tbl[i].dvd);
                chk("div_M_c1",     div_M,         tbl[i].dvs);
            end
            collect(lat, 0);
            chk("rsp_latency", W'(lat), (tbl[i].dvs == '0) ? W'(0) : W'(4));
            chk("start_pulses", W'(start_cnt - sc), (tbl[i].dvs == '0) ? W'(0) : W'(1));
        end

        // Both requesters held valid: grants alternate 0,1,0 after reset.
        reset_dut();
        set_ops(0, 32'd50, 32'd6);
        set_ops(1, 32'd81, 32'd9);
        bus.req_valid = 2'b11;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rr_grant", W'(bus.req_ready), W'(NREQ'(1) << exp_g[i]));
            if (exp_g[i] == 0) push_exp(0, 32'd8, 32'd2, 1'b0);
            else               push_exp(1, 32'd9, 32'd0, 1'b0);
            tick();
            chk("rr_busy_ready", W'(bus.req_ready), '0);
            collect(lat, 0);
        end
        bus.req_valid = '0;
        tick();

        // Response backpressure: data stable, other requester waits, IDLE right after release.
        issue(1, 32'd90, 32'd4);
        push_exp(1, 32'd22, 32'd2, 1'b0);
        set_ops(0, 32'd7, 32'd7);
        bus.req_valid = 2'b01;
        collect(lat, 10);
        chk("post_release_ready", W'(bus.req_ready), W'(2'b01));
        push_exp(0, 32'd1, 32'd0, 1'b0);
        tick();
        bus.req_valid = '0;
        collect(lat, 0);

        // Reset during WAIT abandons the transaction; a late div_done is ignored.
        model_en = 1'b0;
        sc = start_cnt;
        issue(1, 32'd100, 32'd7);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_rsp_valid", W'(bus.rsp_valid), '0);
        chk("midrst_div_start", W'(div_start),     '0);
        chk("midrst_div_Q",     div_Q,             '0);
        chk("midrst_div_M",     div_M,             '0);
        chk("midrst_rsp_id",    W'(bus.rsp_id),    '0);
        chk("midrst_rsp_quot",  bus.rsp_quot,      '0);
        chk("midrst_req_ready", W'(bus.req_ready), '0);
        rst = 1'b0;
        manual_done = 1'b1;
        tick();
        manual_done = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.rsp_valid != '0 || div_start) seen = 1'b1;
        end
        chk("late_done_ignored", W'(seen), '0);
        chk("midrst_start_count", W'(start_cnt - sc), W'(1));
        model_en = 1'b1;

`ifdef DIV_TIMEOUT_EN
        // Watchdog expiry, then a 2-cycle grant holdoff.
        model_en = 1'b0;
        issue(0, 32'd77, 32'd3);
        push_exp(0, 32'd0, 32'd0, 1'b1);
        collect(lat, 0);
        chk("timeout_latency", W'(lat), W'(TO + 1));
        set_ops(1, 32'd20, 32'd4);
        bus.req_valid = 2'b10;
        #1;
        chk("holdoff_1", W'(bus.req_ready), '0);
        tick();
        chk("holdoff_2", W'(bus.req_ready), '0);
        tick();
        chk("holdoff_end", W'(bus.req_ready), W'(2'b10));
        model_en = 1'b1;
        push_exp(1, 32'd5, 32'd0, 1'b0);
        tick();
        bus.req_valid = '0;
        collect(lat, 0);
`endif

        chk("scoreboard_empty", W'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
